// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// through a single 1-bit full-subtractor; results are registered on completion.
module serial_subtractor_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;

        d_bit   = a_q[0] ^ b_q[0] ^ br_q;
        br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        // New difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH steps.
        res_shift             = res_q >> 1;
        res_shift[WIDTH-1]    = d_bit;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                res_d = res_shift;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    diff_d  = res_shift;
                    bout_d  = br_next;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

    assign ready = (state_q == StIdle);
    assign busy  = (state_q == StBusy);
    assign done  = (state_q == StDone);
    assign diff  = diff_q;
    assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Self-checking bench for serial_subtractor_4bit: scoreboard of expected {bout, diff}
// pushed on acceptance and popped by a monitor on every done pulse.
module tb_serial_subtractor_4bit;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    int errors    = 0;
    int checks    = 0;
    int done_seen = 0;
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] last_res;

    serial_subtractor_4bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic c);
        logic [WIDTH:0] t;
        t = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, c};
        return t; // t[WIDTH] is the underflow borrow
    endfunction

    // Scoreboard consumer
    always @(posedge clk) begin
        logic [WIDTH:0] e;
        #1;
        if (done === 1'b1) begin
            done_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got diff=%h bout=%b, no result expected",
                         diff, bout);
            end else begin
                e = exp_q.pop_front();
                if ({bout, diff} !== e) begin
                    errors++;
                    $display("FAIL result: got bout=%b diff=%h, expected bout=%b diff=%h",
                             bout, diff, e[WIDTH], e[WIDTH-1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation from IDLE and run it to the next IDLE cycle.
    task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic c);
        a = x; b = y; bin = c; start = 1'b1;
        exp_q.push_back(ref_sub(x, y, c));
        last_res = ref_sub(x, y, c);
        step();
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
        repeat (WIDTH + 1) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #2;
        checks++;
        if ({ready, busy, done, bout, diff} !== {3'b100, 1'b0, {WIDTH{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b bsy=%b dn=%b bout=%b diff=%h, expected 1 0 0 0 0",
                     ready, busy, done, bout, diff);
        end
        step(); step();
        rst_n = 1'b1;
        last_res = '0;
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_seen;
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL basic_ready_before: got %b expected 1", ready);
        end
        a = 4'd5; b = 4'd3; bin = 1'b0; start = 1'b1;
        exp_q.push_back(ref_sub(4'd5, 4'd3, 1'b0));
        last_res = ref_sub(4'd5, 4'd3, 1'b0);
        step();
        start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            checks++;
            if ({ready, busy, done} !== 3'b010) begin
                errors++;
                $display("FAIL basic_busy_cycle%0d: got rdy/bsy/dn=%b expected 010", i + 1,
                         {ready, busy, done});
            end
            step();
        end
        checks++;
        if ({ready, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL basic_done_cycle: got rdy/bsy/dn=%b expected 001", {ready, busy, done});
        end
        step();
        checks++;
        if ({ready, busy, done, bout, diff} !== {3'b100, 1'b0, 4'd2}) begin
            errors++;
            $display("FAIL basic_after_done: got rdy/bsy/dn=%b bout=%b diff=%h expected 100 0 2",
                     {ready, busy, done}, bout, diff);
        end
        checks++;
        if (done_seen - d0 !== 1) begin
            errors++; $display("FAIL basic_done_count: got %0d expected 1", done_seen - d0);
        end
    endtask

    task automatic test_vectors();
        do_op(4'd3, 4'd5, 1'b0);
        do_op(4'd0, 4'd0, 1'b1);
        do_op(4'd15, 4'd15, 1'b0);
        do_op(4'd15, 4'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int d0;
        logic [WIDTH:0] hold_val, new_exp;
        d0 = done_seen;
        hold_val = last_res;
        new_exp = '0;
        start = 1'b1;
        for (int k = 0; k < 24; k++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
            checks++;
            case (k % 6)
                0: begin
                    if (ready !== 1'b1) begin
                        errors++; $display("FAIL b2b_ready k=%0d: got %b expected 1", k, ready);
                    end
                    new_exp = ref_sub(a, b, bin);
                    exp_q.push_back(new_exp);
                end
                5: begin
                    if (done !== 1'b1) begin
                        errors++; $display("FAIL b2b_done k=%0d: got %b expected 1", k, done);
                    end
                    hold_val = new_exp;
                end
                default: begin
                    if ({busy, bout, diff} !== {1'b1, hold_val}) begin
                        errors++;
                        $display("FAIL b2b_hold k=%0d: got busy=%b bout/diff=%h expected 1 %h",
                                 k, busy, {bout, diff}, hold_val);
                    end
                end
            endcase
            step();
        end
        start = 1'b0;
        last_res = hold_val;
        checks++;
        if (done_seen - d0 !== 4) begin
            errors++; $display("FAIL b2b_done_count: got %0d expected 4", done_seen - d0);
        end
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_seen;
        a = 4'd9; b = 4'd2; bin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, busy, done, bout, diff} !== {3'b100, 1'b0, {WIDTH{1'b0}}}) begin
            errors++;
            $display("FAIL abort_state: got rdy=%b bsy=%b dn=%b bout=%b diff=%h, expected 1 0 0 0 0",
                     ready, busy, done, bout, diff);
        end
        #1;
        rst_n = 1'b1;
        do_op(4'd6, 4'd9, 1'b1);
        checks++;
        if (done_seen - d0 !== 1) begin
            errors++; $display("FAIL abort_done_count: got %0d expected 1", done_seen - d0);
        end
    endtask

    task automatic test_exhaustive();
        int d0;
        d0 = done_seen;
        for (int i = 0; i < (1 << WIDTH); i++)
            for (int j = 0; j < (1 << WIDTH); j++)
                for (int c = 0; c < 2; c++)
                    do_op(WIDTH'(i), WIDTH'(j), 1'(c));
        checks++;
        if (done_seen - d0 !== 2 * (1 << (2 * WIDTH))) begin
            errors++;
            $display("FAIL sweep_done_count: got %0d expected %0d", done_seen - d0,
                     2 * (1 << (2 * WIDTH)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_back_to_back();
        test_abort();
        test_exhaustive();
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending results expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
